// File: rtl/sysid_ext_pkg.sv
// -----------------------------------------------------------------------------
// sysid_ext_pkg
// Shared constants for the system identification slave: the word address map,
// the CAPS bit layout, the uptime counter width, and a helper that builds the
// CAPS word from the build configuration.
// -----------------------------------------------------------------------------
package sysid_ext_pkg;

  // Word address map
  localparam int unsigned ADDR_ID        = 0;
  localparam int unsigned ADDR_TIMESTAMP = 1;
  localparam int unsigned ADDR_VERSION   = 2;
  localparam int unsigned ADDR_SCRATCH   = 3;
  localparam int unsigned ADDR_UPTIME_LO = 4;
  localparam int unsigned ADDR_UPTIME_HI = 5;
  localparam int unsigned ADDR_CAPS      = 6;

  // CAPS layout
  localparam int unsigned CAPS_UPTIME_BIT = 0;
  localparam int unsigned CAPS_PRESC_LSB  = 8;
  localparam int unsigned CAPS_PRESC_MSB  = 23;

  localparam int unsigned UPTIME_W = 64;

  // CAPS reports nothing about the prescaler when the counter is not built,
  // so firmware can treat CAPS == 0 as "no uptime".
  function automatic logic [31:0] caps_word(input logic uptime_en,
                                            input int unsigned prescale);
    logic [31:0] w_caps;
    w_caps = '0;
    if (uptime_en) begin
      w_caps[CAPS_UPTIME_BIT]                = 1'b1;
      w_caps[CAPS_PRESC_MSB:CAPS_PRESC_LSB]  = 16'(prescale - 1);
    end
    return w_caps;
  endfunction

endpackage

// File: rtl/sysid_uptime.sv
// -----------------------------------------------------------------------------
// sysid_uptime
// Free-running 64-bit uptime counter with a prescaler and a high-word snapshot
// that makes a LO-then-HI read pair coherent.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   snap     in   a read of UPTIME_LO was accepted this cycle
//   count    out  live 64-bit counter value
//   hi_snap  out  high word captured at the last accepted LO read
// -----------------------------------------------------------------------------
module sysid_uptime
  import sysid_ext_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                snap,
  output logic [UPTIME_W-1:0] count,
  output logic [31:0]         hi_snap
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     r_presc;
  logic [UPTIME_W-1:0] r_count;
  logic [31:0]         r_hi_snap;
  logic                w_tick;

  // With PRESCALE = 1 the terminal count is 0, so the counter ticks every cycle.
  assign w_tick = (r_presc == PS_LAST);

  // NOTE: the reset is in the sensitivity list, so assertion clears state
  // immediately rather than at the next clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_hi_snap <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so r_hi_snap captures the
      // pre-edge counter value, the same one the LO read returns.
      r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      if (w_tick) begin
        r_count <= r_count + UPTIME_W'(1);  // all-ones wraps to 0
      end
      if (snap) begin
        r_hi_snap <= r_count[UPTIME_W-1:32];
      end
    end
  end

  assign count   = r_count;
  assign hi_snap = r_hi_snap;

endmodule

// File: rtl/sysid_ext.sv
// -----------------------------------------------------------------------------
// sysid_ext
// Avalon-MM system identification slave. Read-only ID, TIMESTAMP, VERSION and
// CAPS words, a byte-enabled read/write SCRATCH word, and an optional uptime
// counter (built when the macro SYSID_EXT_UPTIME_EN is defined). Fixed read
// latency of one cycle, no waitrequest.
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   chipselect     in   slave select
//   address        in   word address [ADDR_W-1:0]
//   read           in   read strobe (qualified by chipselect)
//   write          in   write strobe (qualified by chipselect)
//   writedata      in   write data [31:0]
//   byteenable     in   write byte lanes [3:0]
//   readdata       out  registered read data [31:0]
//   readdatavalid  out  one-cycle pulse with readdata
// -----------------------------------------------------------------------------
module sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'd588734791,
  parameter logic [31:0] TIMESTAMP   = 32'd1376070339,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned PRESCALE    = 1,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

`ifdef SYSID_EXT_UPTIME_EN
  localparam logic UPTIME_EN = 1'b1;
`else
  localparam logic UPTIME_EN = 1'b0;
`endif

  localparam logic [31:0] CAPS_VALUE = caps_word(UPTIME_EN, PRESCALE);

  logic [31:0]         w_addr;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic [31:0]         w_rdata;
  logic [UPTIME_W-1:0] w_count;
  logic [31:0]         w_hi_snap;
  logic                w_unused;
  logic [31:0]         r_scratch;
  logic [31:0]         r_rdata;
  logic                r_rvalid;

  assign w_addr   = 32'(address);
  // A write always wins; a simultaneous read is dropped without a response.
  assign w_wr_acc = chipselect & write;
  assign w_rd_acc = chipselect & read & ~write;

`ifdef SYSID_EXT_UPTIME_EN
  sysid_uptime #(
    .PRESCALE (PRESCALE)
  ) u_uptime (
    .clk     (clk),
    .reset_n (reset_n),
    .snap    (w_rd_acc && (w_addr == ADDR_UPTIME_LO)),
    .count   (w_count),
    .hi_snap (w_hi_snap)
  );
`else
  assign w_count   = '0;
  assign w_hi_snap = '0;
`endif

  // The live high word is only reachable through the snapshot.
  assign w_unused = ^w_count[UPTIME_W-1:32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= SCRATCH_RST;
    end else if (w_wr_acc && (w_addr == ADDR_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          r_scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_rdata and no latch is inferred.
    w_rdata = '0;
    case (w_addr)
      ADDR_ID:        w_rdata = ID_VALUE;
      ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
      ADDR_VERSION:   w_rdata = VERSION;
      ADDR_SCRATCH:   w_rdata = r_scratch;
      ADDR_UPTIME_LO: w_rdata = w_count[31:0];
      ADDR_UPTIME_HI: w_rdata = w_hi_snap;
      ADDR_CAPS:      w_rdata = CAPS_VALUE;
      default:        w_rdata = '0;
    endcase
  end

  // readdata is only loaded on an accepted read so it holds between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;

endmodule

// File: tb/tb_sysid_ext.sv
// -----------------------------------------------------------------------------
// tb_sysid_ext
// Self-checking bench for sysid_ext. Two instances share the bus signals but
// have separate chipselects: dut0 with PRESCALE=1, dut1 with PRESCALE=4.
// Expected read data is queued per instance when a read is issued and compared
// when readdatavalid appears. Expectations follow SYSID_EXT_UPTIME_EN.
// -----------------------------------------------------------------------------
module tb_sysid_ext;

  localparam logic [31:0] ID_VAL  = 32'd588734791;
  localparam logic [31:0] TS_VAL  = 32'd1376070339;
  localparam logic [31:0] VER_VAL = 32'h0001_0000;
`ifdef SYSID_EXT_UPTIME_EN
  localparam logic        UP_EN   = 1'b1;
  localparam logic [31:0] CAPS0   = 32'h0000_0001;
  localparam logic [31:0] CAPS1   = 32'h0000_0301;
`else
  localparam logic        UP_EN   = 1'b0;
  localparam logic [31:0] CAPS0   = 32'h0000_0000;
  localparam logic [31:0] CAPS1   = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs0, cs1;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rd0, rd1;
  logic        rdv0, rdv1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vt[8];

  always #5 clk = ~clk;

  sysid_ext dut0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .chipselect    (cs0),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (rd0),
    .readdatavalid (rdv0)
  );

  sysid_ext #(.PRESCALE(4)) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .chipselect    (cs1),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (rd1),
    .readdatavalid (rdv1)
  );

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard: pop on every valid response.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (rdv0) begin
        if (q0.size() == 0) check("dut0_unexpected_valid", 1'b0, rd0, 32'h0);
        else begin
          e = q0.pop_front();
          check(e.name, (rd0 >= e.lo) && (rd0 <= e.hi), rd0, e.lo);
        end
      end
      if (rdv1) begin
        if (q1.size() == 0) check("dut1_unexpected_valid", 1'b0, rd1, 32'h0);
        else begin
          e = q1.pop_front();
          check(e.name, (rd1 >= e.lo) && (rd1 <= e.hi), rd1, e.lo);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input int sel, input logic [2:0] a, input string name,
                    input logic [31:0] lo, input logic [31:0] hi, input bit push = 1'b1);
    exp_t e;
    e.name = name; e.lo = lo; e.hi = hi;
    cs0 = (sel == 0); cs1 = (sel == 1);
    read = 1'b1; write = 1'b0; address = a;
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk); #1;
    cs0 = 1'b0; cs1 = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    cs0 = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    @(posedge clk); #1;
    cs0 = 1'b0; write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{3'd0, ID_VAL,  ID_VAL,  "id"};
    vt[1] = '{3'd1, TS_VAL,  TS_VAL,  "timestamp"};
    vt[2] = '{3'd2, VER_VAL, VER_VAL, "version"};
    vt[3] = '{3'd6, CAPS0,   CAPS0,   "caps"};
    vt[4] = '{3'd3, 32'h0,   32'h0,   "scratch_rst"};
    vt[5] = '{3'd4, 32'h0,   UP_EN ? 32'd100 : 32'h0, "uptime_lo_early"};
    vt[6] = '{3'd5, 32'h0,   32'h0,   "uptime_hi_early"};
    vt[7] = '{3'd7, 32'h0,   32'h0,   "addr7_zero"};

    reset_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    idle(3);
    check("rst_readdata0",  rd0  == 32'h0, rd0, 32'h0);
    check("rst_valid0",     rdv0 == 1'b0, 32'(rdv0), 32'h0);
    check("rst_readdata1",  rd1  == 32'h0, rd1, 32'h0);
    check("rst_valid1",     rdv1 == 1'b0, 32'(rdv1), 32'h0);
    reset_n = 1'b1;

    // Back-to-back table reads, one response per cycle
    for (int i = 0; i < 8; i++) rd(0, vt[i].addr, vt[i].name, vt[i].lo, vt[i].hi);
    idle(2);

    // Latency and hold
    rd(0, 3'd0, "id_latency", ID_VAL, ID_VAL);
    check("valid_after_one_edge", rdv0 == 1'b1, 32'(rdv0), 32'h1);
    idle(1);
    check("valid_one_cycle", rdv0 == 1'b0, 32'(rdv0), 32'h0);
    check("readdata_holds", rd0 == ID_VAL, rd0, ID_VAL);

    // Byte-enabled scratch write, then an ignored write to ID
    wr(3'd3, 32'hDEAD_BEEF, 4'b0101);
    rd(0, 3'd3, "scratch_be", 32'h00AD_00EF, 32'h00AD_00EF);
    wr(3'd0, 32'h1111_1111, 4'hF);
    rd(0, 3'd0, "id_ro", ID_VAL, ID_VAL);
    idle(1);

    // Read and write together: write wins, no response
    cs0 = 1'b1; read = 1'b1; write = 1'b1; address = 3'd3;
    writedata = 32'h1234_5678; byteenable = 4'hF;
    @(posedge clk); #1;
    cs0 = 1'b0; read = 1'b0; write = 1'b0;
    check("rw_no_valid", rdv0 == 1'b0, 32'(rdv0), 32'h0);
    rd(0, 3'd3, "rw_write_done", 32'h1234_5678, 32'h1234_5678);
    idle(1);

    // Read without chipselect is ignored
    read = 1'b1; address = 3'd0;
    @(posedge clk); #1;
    read = 1'b0;
    check("no_cs_no_valid", rdv0 == 1'b0, 32'(rdv0), 32'h0);

    // Reset asserted while the response is being presented
    rd(0, 3'd0, "unused", 32'h0, 32'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("reset_clears_valid", rdv0 == 1'b0, 32'(rdv0), 32'h0);
    check("reset_clears_data",  rd0 == 32'h0, rd0, 32'h0);
    idle(2);
    reset_n = 1'b1;
    rd(0, 3'd3, "scratch_after_reset", 32'h0, 32'h0);

    // PRESCALE=4: 40 cycles after reset the uptime is about 10
    idle(39);
    rd(1, 3'd4, "uptime_presc4", UP_EN ? 32'd9 : 32'd0, UP_EN ? 32'd11 : 32'd0);
    rd(1, 3'd6, "caps_presc4", CAPS1, CAPS1);
    idle(1);

`ifdef SYSID_EXT_UPTIME_EN
    // Coherent LO/HI pair across a low-word carry
    force dut0.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut0.u_uptime.r_count;
    rd(0, 3'd4, "coherent_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1);
    rd(0, 3'd5, "coherent_hi", 32'h0, 32'h0);
    idle(1);

    // All-ones wraps to zero
    force dut0.u_uptime.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut0.u_uptime.r_count;
    idle(1);
    rd(0, 3'd4, "wrap_lo", 32'h0, 32'h0);
    rd(0, 3'd5, "wrap_hi", 32'h0, 32'h0);
`endif

    idle(3);
    check("q0_drained", q0.size() == 0, 32'(q0.size()), 32'h0);
    check("q1_drained", q1.size() == 0, 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
